// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing from a single fast clock, with the pixel rate set by a clock-enable.
// All outputs are registered and decoded from the next count value, so they never lag the counters.
module vga_timing_gen #(
   parameter int   CLK_DIV   = 2,
   parameter int   H_VISIBLE = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_VISIBLE = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter logic SYNC_POL  = 1'b0
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       ENABLE,
   output logic       PIX_EN,
   output logic [9:0] H_COUNT,
   output logic [9:0] V_COUNT,
   output logic       ACTIVE,
   output logic       HS,
   output logic       VS,
   output logic       LINE_START,
   output logic       FRAME_START
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

   // 11-bit decode bounds: a sync window may end exactly at 1024.
   localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
   localparam logic [10:0] HS_BEGIN  = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
   localparam logic [10:0] VS_BEGIN  = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_next;
   logic             tick;
   logic [9:0]       h_next;
   logic [9:0]       v_next;
   logic             active_next;
   logic             hs_next;
   logic             vs_next;
   logic             line_start_next;
   logic             frame_start_next;

   always_comb begin
      tick     = ENABLE && (div_reg == DIV_LAST);
      div_next = div_reg;
      if (ENABLE) begin
         div_next = tick ? '0 : div_reg + 1'b1;
      end

      // Position the raster will hold after the coming pixel tick.
      h_next = H_COUNT + 10'd1;
      v_next = V_COUNT;
      if (H_COUNT == H_LAST) begin
         h_next = '0;
         v_next = (V_COUNT == V_LAST) ? '0 : V_COUNT + 10'd1;
      end

      active_next      = ({1'b0, h_next} < H_VIS_END) && ({1'b0, v_next} < V_VIS_END);
      hs_next          = (({1'b0, h_next} >= HS_BEGIN) && ({1'b0, h_next} < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_next          = (({1'b0, v_next} >= VS_BEGIN) && ({1'b0, v_next} < VS_END)) ? SYNC_POL : ~SYNC_POL;
      line_start_next  = tick && (h_next == '0);
      frame_start_next = line_start_next && (v_next == '0);
   end

   always_ff @(posedge CLOCK_50 or negedge RESET) begin
      if (!RESET) begin
         div_reg     <= '0;
         PIX_EN      <= 1'b0;
         H_COUNT     <= H_LAST;
         V_COUNT     <= V_LAST;
         ACTIVE      <= 1'b0;
         HS          <= ~SYNC_POL;
         VS          <= ~SYNC_POL;
         LINE_START  <= 1'b0;
         FRAME_START <= 1'b0;
      end else begin
         div_reg     <= div_next;
         PIX_EN      <= tick;
         LINE_START  <= line_start_next;
         FRAME_START <= frame_start_next;
         // Level outputs only move with the counters, so ENABLE=0 freezes them.
         if (tick) begin
            H_COUNT <= h_next;
            V_COUNT <= v_next;
            ACTIVE  <= active_next;
            HS      <= hs_next;
            VS      <= vs_next;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus two tiny rasters (CLK_DIV=1 and CLK_DIV=3,
// active-high sync) checked against a tick-count reference model, a vector table and hand sequences.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       act;
      logic       hs;
      logic       vs;
      logic       pix;
      logic       ls;
      logic       fs;
   } obs_t;

   typedef struct {
      int   edge_n;
      obs_t x;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a  = 1'b0;
   logic rst_bc = 1'b0;
   logic en_a   = 1'b1;
   logic en_b   = 1'b1;
   logic en_c   = 1'b1;

   logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
   logic pix_a, act_a, hs_a, vs_a, ls_a, fs_a;
   logic pix_b, act_b, hs_b, vs_b, ls_b, fs_b;
   logic pix_c, act_c, hs_c, vs_c, ls_c, fs_c;

   int checks   = 0;
   int failures = 0;

   vga_timing_gen dut_a (
      .CLOCK_50(clk), .RESET(rst_a), .ENABLE(en_a), .PIX_EN(pix_a),
      .H_COUNT(h_a), .V_COUNT(v_a), .ACTIVE(act_a), .HS(hs_a), .VS(vs_a),
      .LINE_START(ls_a), .FRAME_START(fs_a)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
      .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
   ) dut_b (
      .CLOCK_50(clk), .RESET(rst_bc), .ENABLE(en_b), .PIX_EN(pix_b),
      .H_COUNT(h_b), .V_COUNT(v_b), .ACTIVE(act_b), .HS(hs_b), .VS(vs_b),
      .LINE_START(ls_b), .FRAME_START(fs_b)
   );

   vga_timing_gen #(
      .CLK_DIV(3), .H_VISIBLE(5), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
   ) dut_c (
      .CLOCK_50(clk), .RESET(rst_bc), .ENABLE(en_c), .PIX_EN(pix_c),
      .H_COUNT(h_c), .V_COUNT(v_c), .ACTIVE(act_c), .HS(hs_c), .VS(vs_c),
      .LINE_START(ls_c), .FRAME_START(fs_c)
   );

   obs_t got_a, got_b, got_c;
   assign got_a = {h_a, v_a, act_a, hs_a, vs_a, pix_a, ls_a, fs_a};
   assign got_b = {h_b, v_b, act_b, hs_b, vs_b, pix_b, ls_b, fs_b};
   assign got_c = {h_c, v_c, act_c, hs_c, vs_c, pix_c, ls_c, fs_c};

   // Reference state: enabled clock edges since reset release and ENABLE at the latest edge.
   int n_a = 0, n_b = 0, n_c = 0;
   bit ee_a = 1'b0, ee_b = 1'b0, ee_c = 1'b0;

   always @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         n_a  <= 0;
         ee_a <= 1'b0;
      end else begin
         ee_a <= en_a;
         if (en_a) n_a <= n_a + 1;
      end
   end

   always @(posedge clk or negedge rst_bc) begin
      if (!rst_bc) begin
         n_b  <= 0;
         n_c  <= 0;
         ee_b <= 1'b0;
         ee_c <= 1'b0;
      end else begin
         ee_b <= en_b;
         ee_c <= en_c;
         if (en_b) n_b <= n_b + 1;
         if (en_c) n_c <= n_c + 1;
      end
   end

   // Every d-th enabled edge is a pixel tick; tick t (t>=1) shows raster pixel t-1 in row-major order.
   function automatic obs_t ref_model(input int n, input bit en_edge, input int d,
                                      input int hv, input int hf, input int hsw, input int hb,
                                      input int vv, input int vf, input int vsw, input int vb,
                                      input logic pol);
      obs_t r;
      int   ht, vt, t, p, hh, vl;
      ht    = hv + hf + hsw + hb;
      vt    = vv + vf + vsw + vb;
      t     = n / d;
      r.pix = en_edge && (n > 0) && (n % d == 0);
      if (t == 0) begin
         r.h   = 10'(ht - 1);
         r.v   = 10'(vt - 1);
         r.act = 1'b0;
         r.hs  = ~pol;
         r.vs  = ~pol;
         r.ls  = 1'b0;
         r.fs  = 1'b0;
      end else begin
         p     = t - 1;
         hh    = p % ht;
         vl    = (p / ht) % vt;
         r.h   = 10'(hh);
         r.v   = 10'(vl);
         r.act = (hh < hv) && (vl < vv);
         r.hs  = (hh >= hv + hf && hh < hv + hf + hsw) ? pol : ~pol;
         r.vs  = (vl >= vv + vf && vl < vv + vf + vsw) ? pol : ~pol;
         r.ls  = r.pix && (hh == 0);
         r.fs  = r.pix && (hh == 0) && (vl == 0);
      end
      return r;
   endfunction

   function automatic obs_t exp_a();
      return ref_model(n_a, ee_a, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic obs_t exp_b();
      return ref_model(n_b, ee_b, 1, 4, 1, 1, 1, 2, 1, 1, 1, 1'b0);
   endfunction

   function automatic obs_t exp_c();
      return ref_model(n_c, ee_c, 3, 5, 2, 3, 2, 3, 1, 2, 1, 1'b1);
   endfunction

   // flags = {act, hs, vs, pix, ls, fs}
   function automatic obs_t mk(input int h, input int v, input logic [5:0] flags);
      return {10'(h), 10'(v), flags};
   endfunction

   task automatic check(input string tag, input obs_t got, input obs_t want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got h=%0d v=%0d act=%b hs=%b vs=%b pix=%b ls=%b fs=%b, want h=%0d v=%0d act=%b hs=%b vs=%b pix=%b ls=%b fs=%b",
                  tag, got.h, got.v, got.act, got.hs, got.vs, got.pix, got.ls, got.fs,
                  want.h, want.v, want.act, want.hs, want.vs, want.pix, want.ls, want.fs);
      end
   endtask

   task automatic check_val(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_a(input int target, input int budget, input string tag);
      bit found = 1'b0;
      for (int k = 0; k < budget && !found; k++) begin
         step();
         if (got_a.pix && got_a.h == 10'(target)) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL %s: H=%0d not reached within %0d clocks (last h=%0d)", tag, target, budget, got_a.h);
      end
   endtask

   // Measures one whole frame, FRAME_START to FRAME_START, on dut_b (idx 0) or dut_c (idx 1).
   task automatic measure(input int idx, input int budget, input logic pol, input string tag,
                          input int want_period, input int want_hs, input int want_vs, input int want_pix);
      obs_t g;
      bit   found = 1'b0;
      int   period = 0, hs_n = 0, vs_n = 0, pix_n = 0;
      g = (idx == 0) ? got_b : got_c;
      for (int k = 0; k < budget && !found; k++) begin
         step();
         g = (idx == 0) ? got_b : got_c;
         if (g.fs) found = 1'b1;
      end
      if (found) begin
         found  = 1'b0;
         period = 1;
         hs_n   = (g.hs == pol) ? 1 : 0;
         vs_n   = (g.vs == pol) ? 1 : 0;
         pix_n  = g.pix ? 1 : 0;
         for (int k = 0; k < budget && !found; k++) begin
            step();
            g = (idx == 0) ? got_b : got_c;
            if (g.fs) begin
               found = 1'b1;
            end else begin
               period++;
               if (g.hs == pol) hs_n++;
               if (g.vs == pol) vs_n++;
               if (g.pix) pix_n++;
            end
         end
      end
      if (!found) period = -1;
      check_val({tag, "_frame_period"}, period, want_period);
      check_val({tag, "_hs_asserted"}, hs_n, want_hs);
      check_val({tag, "_vs_asserted"}, vs_n, want_vs);
      check_val({tag, "_pix_ticks"}, pix_n, want_pix);
      $display("%s frame: period=%0d hs=%0d vs=%0d pix=%0d", tag, period, hs_n, vs_n, pix_n);
   endtask

   vec_t tbl[15];
   int   e;

   initial begin
      // Default raster, ENABLE held high; edge counts from reset release.
      tbl[0]  = '{0,    mk(799, 524, 6'b011000)};
      tbl[1]  = '{1,    mk(799, 524, 6'b011000)};
      tbl[2]  = '{2,    mk(0,   0,   6'b111111)};
      tbl[3]  = '{3,    mk(0,   0,   6'b111000)};
      tbl[4]  = '{4,    mk(1,   0,   6'b111100)};
      tbl[5]  = '{1280, mk(639, 0,   6'b111100)};
      tbl[6]  = '{1281, mk(639, 0,   6'b111000)};
      tbl[7]  = '{1282, mk(640, 0,   6'b011100)};
      tbl[8]  = '{1312, mk(655, 0,   6'b011100)};
      tbl[9]  = '{1314, mk(656, 0,   6'b001100)};
      tbl[10] = '{1504, mk(751, 0,   6'b001100)};
      tbl[11] = '{1506, mk(752, 0,   6'b011100)};
      tbl[12] = '{1600, mk(799, 0,   6'b011100)};
      tbl[13] = '{1602, mk(0,   1,   6'b111110)};
      tbl[14] = '{1603, mk(0,   1,   6'b111000)};

      #12;
      check("reset_state", got_a, tbl[0].x);
      check("reset_state_c", got_c, mk(11, 6, 6'b000000));
      $display("vec 0 edge=0 h=%0d v=%0d pix=%b", got_a.h, got_a.v, got_a.pix);
      rst_a  = 1'b1;
      rst_bc = 1'b1;
      e      = 0;
      for (int i = 1; i < 15; i++) begin
         while (e < tbl[i].edge_n) begin
            step();
            e++;
         end
         check($sformatf("vec%0d", i), got_a, tbl[i].x);
         $display("vec %0d edge=%0d h=%0d v=%0d pix=%b", i, e, got_a.h, got_a.v, got_a.pix);
      end

      // Random ENABLE patterns on all three instances against the reference model.
      for (int k = 0; k < 3000; k++) begin
         en_a = ($urandom_range(0, 7) != 0);
         en_b = ($urandom_range(0, 3) != 0);
         en_c = ($urandom_range(0, 1) != 0);
         step();
         check("rand_a", got_a, exp_a());
         check("rand_b", got_b, exp_b());
         check("rand_c", got_c, exp_c());
      end
      $display("random phase: 3000 clocks, a=(%0d,%0d) b=(%0d,%0d) c=(%0d,%0d)",
               got_a.h, got_a.v, got_b.h, got_b.v, got_c.h, got_c.v);

      // Freeze at H=300 for 50 clocks, then resume from the held divider phase.
      en_a  = 1'b1;
      rst_a = 1'b0;
      step();
      rst_a = 1'b1;
      wait_a(300, 1000, "reach_h300");
      en_a = 1'b0;
      for (int k = 0; k < 50; k++) begin
         step();
         check("freeze", got_a, mk(300, 0, 6'b111000));
      end
      en_a = 1'b1;
      step();
      check("resume_e1", got_a, mk(300, 0, 6'b111000));
      step();
      check("resume_e2", got_a, mk(301, 0, 6'b111100));
      $display("freeze sequence: h=%0d after resume", got_a.h);

      // Asynchronous reset in mid clock period, then the first tick wraps to (0,0).
      wait_a(700, 1000, "reach_h700");
      #2;
      rst_a = 1'b0;
      #1;
      check("async_reset", got_a, mk(799, 524, 6'b011000));
      step();
      check("reset_hold", got_a, mk(799, 524, 6'b011000));
      rst_a = 1'b1;
      step();
      check("release_e1", got_a, mk(799, 524, 6'b011000));
      step();
      check("release_e2", got_a, mk(0, 0, 6'b111111));
      $display("reset sequence: h=%0d v=%0d fs=%b", got_a.h, got_a.v, got_a.fs);

      // Whole-frame measurements on the small rasters with ENABLE held high.
      en_b   = 1'b1;
      en_c   = 1'b1;
      rst_bc = 1'b0;
      step();
      rst_bc = 1'b1;
      measure(0, 100, 1'b0, "b", 35, 5, 7, 35);
      measure(1, 600, 1'b1, "c", 252, 63, 72, 84);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
